// File: rtl/ledspi_tx.sv
// ledspi_tx: APA102-style frame serializer (SPI mode 0, MSB first).
// Accepts one START/LED/END request while idle, builds the 32-bit frame and
// shifts it out on mosi/sck with CLK_DIV system clocks per sck half-period.
// Build option: define LEDSPI_BRIGHTNESS_EN to add bright_input[4:0], which
// is latched with the colours and replaces GLOBAL_BRIGHT in LED frames.
module ledspi_tx #(
   parameter int unsigned CLK_DIV       = 4,
   parameter logic [4:0]  GLOBAL_BRIGHT = 5'h1F
) (
   input  logic       ledspi_clk,
   input  logic       ledspi_reset_n,
   input  logic [1:0] type_input,
   input  logic [7:0] blue_input,
   input  logic [7:0] green_input,
   input  logic [7:0] red_input,
`ifdef LEDSPI_BRIGHTNESS_EN
   input  logic [4:0] bright_input,
`endif
   input  logic       ledspi_start,
   output logic       ledspi_busy,
   output logic       mosi,
   output logic       sck
);

   // Last divider count of each sck half-period.
   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi} state_t;

   state_t      state_q;
   logic [31:0] shift_q;
   logic [4:0]  bit_cnt_q;
   logic [7:0]  div_q;
   logic [4:0]  bright_sel;
   logic [31:0] frame;

`ifdef LEDSPI_BRIGHTNESS_EN
   assign bright_sel = bright_input;
`else
   assign bright_sel = GLOBAL_BRIGHT;
`endif

   // Frame word for the requested type; type 3 is sent as END.
   always_comb begin
      frame = 32'hFFFF_FFFF;
      case (type_input)
         2'd0:    frame = 32'h0000_0000;
         2'd1:    frame = {3'b111, bright_sel, blue_input, green_input, red_input};
         default: frame = 32'hFFFF_FFFF;
      endcase
   end

   // mosi is the shift register MSB; the register is cleared whenever idle.
   assign mosi = shift_q[31];

   // Serializer FSM: load on accept, then alternate sck low/high phases.
   always_ff @(posedge ledspi_clk or negedge ledspi_reset_n) begin
      if (!ledspi_reset_n) begin
         state_q     <= StIdle;
         shift_q     <= 32'h0;
         bit_cnt_q   <= 5'd0;
         div_q       <= 8'd0;
         sck         <= 1'b0;
         ledspi_busy <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (ledspi_start) begin
                  shift_q     <= frame;
                  bit_cnt_q   <= 5'd0;
                  div_q       <= 8'd0;
                  ledspi_busy <= 1'b1;
                  state_q     <= StShiftLo;
               end
            end
            StShiftLo: begin
               if (div_q == DivLast) begin
                  div_q   <= 8'd0;
                  sck     <= 1'b1;
                  state_q <= StShiftHi;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            StShiftHi: begin
               if (div_q == DivLast) begin
                  div_q <= 8'd0;
                  sck   <= 1'b0;
                  if (bit_cnt_q == 5'd31) begin
                     // Last bit done: drop busy and park mosi low.
                     bit_cnt_q   <= 5'd0;
                     shift_q     <= 32'h0;
                     ledspi_busy <= 1'b0;
                     state_q     <= StIdle;
                  end else begin
                     // Next bit appears on the falling edge (mode 0).
                     shift_q   <= {shift_q[30:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     state_q   <= StShiftLo;
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ledspi_tx.sv
// tb_ledspi_tx: randomized self-checking bench for ledspi_tx (CLK_DIV=4).
// A passive monitor rebuilds each shifted word from mosi at sck rises and
// records busy high/low lengths; a frame-level model predicts the words.
module tb_ledspi_tx;

   localparam int unsigned ClkDiv = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] type_in;
   logic [7:0] blue, green, red;
   logic [4:0] bright;
   logic       start;
   logic       busy, mosi, sck;

   int n_checks = 0;
   int n_pass   = 0;

   ledspi_tx #(
      .CLK_DIV       (ClkDiv),
      .GLOBAL_BRIGHT (5'h1F)
   ) dut (
      .ledspi_clk     (clk),
      .ledspi_reset_n (rst_n),
      .type_input     (type_in),
      .blue_input     (blue),
      .green_input    (green),
      .red_input      (red),
`ifdef LEDSPI_BRIGHTNESS_EN
      .bright_input   (bright),
`endif
      .ledspi_start   (start),
      .ledspi_busy    (busy),
      .mosi           (mosi),
      .sck            (sck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Frame-level reference: what the wand should receive for a request.
   function automatic logic [31:0] model(input logic [1:0] t, input logic [7:0] b,
                                         input logic [7:0] g, input logic [7:0] r,
                                         input logic [4:0] br);
      logic [4:0] lvl;
`ifdef LEDSPI_BRIGHTNESS_EN
      lvl = br;
`else
      lvl = 5'h1F;
      if (br == 5'h00) lvl = 5'h1F;
`endif
      if (t == 2'd0) return 32'h0000_0000;
      if (t == 2'd1) return {3'b111, lvl, b, g, r};
      return 32'hFFFF_FFFF;
   endfunction

   // Passive monitor, sampled on the falling system clock edge.
   logic [31:0] cap;
   int          rises, blen, glen, unstable, idle_rises;
   logic        sck_p, mosi_p, busy_p;
   logic [31:0] q_word[$];
   int          q_rise[$];
   int          q_len[$];
   int          q_gap[$];

   initial begin
      cap = 0; rises = 0; blen = 0; glen = 0; unstable = 0; idle_rises = 0;
      sck_p = 0; mosi_p = 0; busy_p = 0;
   end

   always @(negedge clk) begin
      if (!busy && busy_p) begin
         q_word.push_back(cap);
         q_rise.push_back(rises);
         q_len.push_back(blen);
         glen = 0;
      end
      if (busy && !busy_p) begin
         q_gap.push_back(glen);
         cap = 0; rises = 0; blen = 0;
      end
      if (busy) blen++;
      else glen++;
      if (sck && !sck_p) begin
         cap = {cap[30:0], mosi};
         rises++;
         if (!busy) idle_rises++;
      end
      if (sck && sck_p && (mosi !== mosi_p)) unstable++;
      sck_p  = sck;
      mosi_p = mosi;
      busy_p = busy;
   end

   task automatic flush_queues();
      q_word.delete(); q_rise.delete(); q_len.delete(); q_gap.delete();
   endtask

   task automatic pop_frame(input string tag, input logic [31:0] exp);
      check_eq({tag, "_avail"}, 32'(q_word.size() > 0), 32'd1);
      if (q_word.size() > 0) begin
         check_eq({tag, "_word"}, q_word.pop_front(), exp);
         check_eq({tag, "_rises"}, 32'(q_rise.pop_front()), 32'd32);
         check_eq({tag, "_busy_len"}, 32'(q_len.pop_front()), 32'(64 * ClkDiv));
      end
   endtask

   // One request from idle; inputs and start are scrambled while busy.
   task automatic run_frame(input string tag, input logic [1:0] t, input logic [7:0] b,
                            input logic [7:0] g, input logic [7:0] r, input logic [4:0] br);
      logic [31:0] exp;
      int n;
      exp = model(t, b, g, r, br);
      @(negedge clk);
      type_in = t; blue = b; green = g; red = r; bright = br; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
      check_eq({tag, "_mosi0"}, 32'(mosi), 32'(exp[31]));
      check_eq({tag, "_sck_low"}, 32'(sck), 32'd0);
      n = 0;
      while (busy && n < 3000) begin
         type_in = 2'($urandom);
         blue    = 8'($urandom);
         green   = 8'($urandom);
         red     = 8'($urandom);
         bright  = 5'($urandom);
         start   = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check_eq({tag, "_done"}, 32'(n < 3000), 32'd1);
      @(posedge clk);
      pop_frame(tag, exp);
      check_eq({tag, "_mosi_stable"}, 32'(unstable), 32'd0);
   endtask

   task automatic wait_busy(input logic lvl, output int ok);
      int n;
      n = 0;
      while (busy !== lvl && n < 3000) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 3000) ? 1 : 0;
   endtask

   initial begin
      int ok;
      logic [1:0] t;
      rst_n = 1'b0; type_in = 0; blue = 0; green = 0; red = 0; bright = 0; start = 0;
      #1;
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_sck", 32'(sck), 32'd0);
      check_eq("reset_mosi", 32'(mosi), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      flush_queues();

      // START frame: all zeros, 32 rises, busy 64*CLK_DIV clocks.
      run_frame("start", 2'd0, 8'h12, 8'h34, 8'h56, 5'h07);
      // Fixed LED colours.
      run_frame("led_c8", 2'd1, 8'hC8, 8'h96, 8'h00, 5'h1F);
`ifdef LEDSPI_BRIGHTNESS_EN
      run_frame("led_br", 2'd1, 8'h01, 8'h02, 8'h03, 5'h03);
`endif
      run_frame("end", 2'd2, 8'h00, 8'h00, 8'h00, 5'h00);
      run_frame("type3", 2'd3, 8'hAA, 8'h55, 8'h0F, 5'h10);

      // Random requests, biased towards LED frames.
      for (int i = 0; i < 8; i++) begin
         t = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd1;
         run_frame("rand", t, 8'($urandom), 8'($urandom), 8'($urandom), 5'($urandom));
      end

      // Back-to-back END then type 3 with start held high.
      flush_queues();
      @(negedge clk);
      type_in = 2'd2; start = 1'b1;
      @(negedge clk);
      type_in = 2'd3;
      wait_busy(1'b0, ok);
      check_eq("b2b_first_done", 32'(ok), 32'd1);
      wait_busy(1'b1, ok);
      check_eq("b2b_second_start", 32'(ok), 32'd1);
      start = 1'b0;
      wait_busy(1'b0, ok);
      check_eq("b2b_second_done", 32'(ok), 32'd1);
      @(posedge clk);
      pop_frame("b2b_a", 32'hFFFF_FFFF);
      pop_frame("b2b_b", 32'hFFFF_FFFF);
      check_eq("b2b_gap_cnt", 32'(q_gap.size()), 32'd2);
      if (q_gap.size() == 2) check_eq("b2b_gap", 32'(q_gap[1]), 32'd1);

      // Asynchronous reset in the middle of bit 12.
      @(negedge clk);
      type_in = 2'd1; blue = 8'hFF; green = 8'hFF; red = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (rises < 13 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         check_eq("rst_reach_bit12", 32'(n < 3000), 32'd1);
      end
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_sck", 32'(sck), 32'd0);
      check_eq("rst_mid_mosi", 32'(mosi), 32'd0);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      idle_rises = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check_eq("rst_no_sck", 32'(idle_rises), 32'd0);
      check_eq("rst_idle_busy", 32'(busy), 32'd0);
      flush_queues();
      run_frame("post_rst", 2'd1, 8'h01, 8'h80, 8'h7E, 5'h11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
